score_display_mux: RTL and testbench

SCORE_DISPLAY_MUX -- requirements
Module: score_display_mux

---
 rtl/score_display_mux.sv | 79 +++++++
 tb/tb_score_display_mux.sv | 119 +++++++++++
 2 files changed

// File: rtl/score_display_mux.sv
// score_display_mux: four-digit multiplexed score display with per-frame digit snapshot,
// leading-zero blanking, player-separator decimal point and game-over blink.
module score_display_mux #(
  parameter int PRESCALE    = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_sh;
  logic [BW-1:0]     r_slot;
  logic              r_hidden;
  logic              w_tick;
  logic              w_hide;
  logic              w_blank;
  logic [3:0]        w_dig;
  logic [6:0]        w_seg;
  assign w_tick  = r_cnt == CW'(PRESCALE - 1);
  assign w_dig   = r_sh[r_idx];
  assign w_hide  = blink_en && r_hidden;
  // Only the tens positions (odd indices) are blanked when zero.
  assign w_blank = r_idx[0] && (w_dig == 4'd0);
  always_comb begin
    w_seg = 7'h3F;
    case (w_dig)
      4'd0: w_seg = 7'h40;
      4'd1: w_seg = 7'h79;
      4'd2: w_seg = 7'h24;
      4'd3: w_seg = 7'h30;
      4'd4: w_seg = 7'h19;
      4'd5: w_seg = 7'h12;
      4'd6: w_seg = 7'h02;
      4'd7: w_seg = 7'h78;
      4'd8: w_seg = 7'h00;
      4'd9: w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_sh     <= '0;
      r_slot   <= '0;
      r_hidden <= 1'b0;
      an       <= 4'hF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (!blink_en) begin
        r_slot   <= '0;
        r_hidden <= 1'b0;
      end else if (w_tick) begin
        r_slot   <= (r_slot == BW'(BLINK_TICKS - 1)) ? '0 : r_slot + 1'b1;
        r_hidden <= (r_slot == BW'(BLINK_TICKS - 1)) ? ~r_hidden : r_hidden;
      end
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_sh <= {dig3, dig2, dig1, dig0};
        an  <= w_hide ? 4'hF : ~(4'b0001 << r_idx);
        seg <= w_blank ? 7'h7F : w_seg;
        dp  <= w_hide || (r_idx != 2'd2);
      end
    end
  end
endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: slot-level scoreboard against a behavioural display model.
module tb_score_display_mux;
  localparam int P = 4;
  localparam int B = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig0 = 4'd0, dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0;
  logic       blink_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  int total = 0;
  int bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last = 12'hFFF;
  int          m_idx = 0;
  int          m_slot = 0;
  logic        m_hid = 1'b0;
  logic [3:0]  m_sh[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [6:0]  tbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  score_display_mux #(.PRESCALE(P), .BLINK_TICKS(B)) dut (
    .clk(clk), .reset(reset), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blink_en(blink_en), .an(an), .seg(seg), .dp(dp)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got{an,seg,dp}=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] model_out();
    logic [3:0] d;
    logic [6:0] s;
    logic       h;
    d = m_sh[m_idx];
    s = (d > 4'd9) ? 7'h3F : tbl[d];
    if ((m_idx == 1 || m_idx == 3) && d == 4'd0) s = 7'h7F;
    h = blink_en && m_hid;
    return {h ? 4'hF : ~(4'b0001 << m_idx), s, h ? 1'b1 : (m_idx != 2)};
  endfunction

  task automatic model_step();
    if (!blink_en) begin
      m_slot = 0;
      m_hid  = 1'b0;
    end else if (m_slot == B - 1) begin
      m_slot = 0;
      m_hid  = !m_hid;
    end else m_slot++;
    if (m_idx == 3) m_sh = '{dig0, dig1, dig2, dig3};
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_slot = 0;
    m_hid = 1'b0;
    m_sh = '{4'd0, 4'd0, 4'd0, 4'd0};
    exp_q.delete();
    last = 12'hFFF;
  endtask

  task automatic slot(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat (P - 1) @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold"}, {an, seg, dp}, last);
      exp_q.push_back(model_out());
      model_step();
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        bad++;
        total++;
        $display("FAIL %s scoreboard empty", tag);
      end else begin
        last = exp_q.pop_front();
        chk(tag, {an, seg, dp}, last);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst", {an, seg, dp}, 12'hFFF);
    reset = 1'b0;
    slot(4, "zero_frame");
    dig3 = 4'd0; dig2 = 4'd7; dig1 = 4'd2; dig0 = 4'd3;
    slot(4, "pre_wrap");
    slot(4, "score_0723");
    slot(1, "idx0");
    dig0 = 4'd5;
    slot(3, "mid_change");
    slot(4, "after_wrap");
    dig0 = 4'd12;
    slot(8, "dash");
    blink_en = 1'b1;
    slot(8, "blink");
    blink_en = 1'b0;
    slot(4, "unblink");
    slot(3, "to_idx2");
    #2 reset = 1'b1;
    #1 chk("rst_async", {an, seg, dp}, 12'hFFF);
    model_reset();
    @(negedge clk);
    chk("rst_hold", {an, seg, dp}, 12'hFFF);
    reset = 1'b0;
    slot(4, "restart");
    slot(4, "restart_next");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
